peripheral_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single 24-bit peripheral bus (the bus feeding GPIO, UART, SPI etc. through PeripheralSelect) between two bus masters. It sits between the masters' bridges and the peripheral bus:
- grants one master at a time, round-robin;
- registers the granted transaction onto the bus;
- honours `peripheralBus_busy` stalls;
- returns read data and a per-master busy handshake.

---
 rtl/peripheral_bus_arbiter_if.sv | 56 +++++
 rtl/peripheral_bus_arbiter.sv | 107 ++++++++++
 tb/tb_peripheral_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/peripheral_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared
// 24-bit peripheral bus.
interface peripheral_bus_arbiter_if;
  logic        master0_we;
  logic        master0_oe;
  logic [23:0] master0_address;
  logic [3:0]  master0_byteSelect;
  logic [31:0] master0_dataWrite;
  logic [31:0] master0_dataRead;
  logic        master0_busy;

  logic        master1_we;
  logic        master1_oe;
  logic [23:0] master1_address;
  logic [3:0]  master1_byteSelect;
  logic [31:0] master1_dataWrite;
  logic [31:0] master1_dataRead;
  logic        master1_busy;

  logic        peripheralBus_we;
  logic        peripheralBus_oe;
  logic [23:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite;
  logic        peripheralBus_busy;
  logic [31:0] peripheralBus_dataRead;
  logic        busTimeout;

  modport slave (
    input  master0_we, master0_oe, master0_address,
    input  master0_byteSelect, master0_dataWrite,
    output master0_dataRead, master0_busy,
    input  master1_we, master1_oe, master1_address,
    input  master1_byteSelect, master1_dataWrite,
    output master1_dataRead, master1_busy,
    output peripheralBus_we, peripheralBus_oe,
    output peripheralBus_address, peripheralBus_byteSelect,
    output peripheralBus_dataWrite,
    input  peripheralBus_busy, peripheralBus_dataRead,
    output busTimeout
  );

  modport master (
    output master0_we, master0_oe, master0_address,
    output master0_byteSelect, master0_dataWrite,
    input  master0_dataRead, master0_busy,
    output master1_we, master1_oe, master1_address,
    output master1_byteSelect, master1_dataWrite,
    input  master1_dataRead, master1_busy,
    input  peripheralBus_we, peripheralBus_oe,
    input  peripheralBus_address, peripheralBus_byteSelect,
    input  peripheralBus_dataWrite,
    output peripheralBus_busy, peripheralBus_dataRead,
    input  busTimeout
  );
endinterface

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin two-master arbiter for the peripheral bus.
// Optional stall watchdog: PERIPHERAL_BUS_ARBITER_TIMEOUT_EN.
module peripheral_bus_arbiter #(
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  peripheral_bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_nx;
  logic        grant, last_grant;
  logic        req0, req1, winner;
  logic        done, tmo;
  logic        cmp0, cmp1;
  logic        pb_we, pb_oe;
  logic [23:0] pb_addr;
  logic [3:0]  pb_bs;
  logic [31:0] pb_wd;

  assign req0 = bus.master0_we | bus.master0_oe;
  assign req1 = bus.master1_we | bus.master1_oe;
  assign winner = (req0 & req1) ? ~last_grant : req1;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wdog;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE)
      wdog <= '0;
    else if (bus.peripheralBus_busy)
      wdog <= wdog + 1'b1;
  end

  assign tmo = (state == GRANT) & bus.peripheralBus_busy & (&wdog);
`else
  assign tmo = 1'b0;
`endif

  assign done = (state == GRANT) & (~bus.peripheralBus_busy | tmo);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req0 | req1) state_nx = GRANT;
      GRANT: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      pb_we      <= 1'b0;
      pb_oe      <= 1'b0;
      pb_addr    <= '0;
      pb_bs      <= '0;
      pb_wd      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req0 | req1)) begin
        grant <= winner;
        if (winner) begin
          pb_we   <= bus.master1_we;
          pb_oe   <= bus.master1_oe & ~bus.master1_we;
          pb_addr <= bus.master1_address;
          pb_bs   <= bus.master1_byteSelect;
          pb_wd   <= bus.master1_dataWrite;
        end else begin
          pb_we   <= bus.master0_we;
          pb_oe   <= bus.master0_oe & ~bus.master0_we;
          pb_addr <= bus.master0_address;
          pb_bs   <= bus.master0_byteSelect;
          pb_wd   <= bus.master0_dataWrite;
        end
      end else if (done) begin
        last_grant <= grant;
        pb_we      <= 1'b0;
        pb_oe      <= 1'b0;
        pb_addr    <= '0;
        pb_bs      <= '0;
        pb_wd      <= '0;
      end
    end
  end

  // completion is masked while reset is asserted so busy follows req
  assign cmp0 = done & ~grant & ~rst;
  assign cmp1 = done & grant & ~rst;

  assign bus.master0_busy = req0 & ~cmp0;
  assign bus.master1_busy = req1 & ~cmp1;
  assign bus.master0_dataRead =
    (cmp0 & ~tmo) ? bus.peripheralBus_dataRead : '1;
  assign bus.master1_dataRead =
    (cmp1 & ~tmo) ? bus.peripheralBus_dataRead : '1;

  assign bus.peripheralBus_we         = pb_we;
  assign bus.peripheralBus_oe         = pb_oe;
  assign bus.peripheralBus_address    = pb_addr;
  assign bus.peripheralBus_byteSelect = pb_bs;
  assign bus.peripheralBus_dataWrite  = pb_wd;
  assign bus.busTimeout               = tmo & ~rst;
endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed-vector bench for peripheral_bus_arbiter.
// Watchdog case depends on PERIPHERAL_BUS_ARBITER_TIMEOUT_EN.
module tb_peripheral_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  peripheral_bus_arbiter_if bus();

  peripheral_bus_arbiter #(.TIMEOUT_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_masters();
    bus.master0_we = 0; bus.master0_oe = 0;
    bus.master1_we = 0; bus.master1_oe = 0;
  endtask

  logic seen_tmo;

  initial begin
    idle_masters();
    bus.master0_address = 0; bus.master0_byteSelect = 0;
    bus.master0_dataWrite = 0;
    bus.master1_address = 0; bus.master1_byteSelect = 0;
    bus.master1_dataWrite = 0;
    bus.peripheralBus_busy = 0;
    bus.peripheralBus_dataRead = 32'h0000_00A5;
    cyc(); cyc();
    smp();
    check("rst_oe", 32'(bus.peripheralBus_oe), 0);
    check("rst_addr", 32'(bus.peripheralBus_address), 0);
    check("rst_busy0", 32'(bus.master0_busy), 0);
    check("rst_dr0", bus.master0_dataRead, 32'hFFFF_FFFF);
    check("rst_tmo", 32'(bus.busTimeout), 0);
    cyc(); rst = 0;

    // single zero-wait read by master0
    bus.master0_oe = 1; bus.master0_address = 24'h030010;
    smp();
    check("rd_busy_T", 32'(bus.master0_busy), 1);
    check("rd_dr_T", bus.master0_dataRead, 32'hFFFF_FFFF);
    cyc(); smp();
    check("rd_oe", 32'(bus.peripheralBus_oe), 1);
    check("rd_we", 32'(bus.peripheralBus_we), 0);
    check("rd_addr", 32'(bus.peripheralBus_address), 32'h030010);
    check("rd_busy_T1", 32'(bus.master0_busy), 0);
    check("rd_dr", bus.master0_dataRead, 32'h0000_00A5);
    cyc(); idle_masters(); smp();
    check("rd_clr", 32'(bus.peripheralBus_oe), 0);
    check("rd_clr_addr", 32'(bus.peripheralBus_address), 0);

    // master1 write with three stall cycles
    bus.master1_we = 1; bus.master1_address = 24'h020004;
    bus.master1_dataWrite = 32'hDEADBEEF;
    bus.master1_byteSelect = 4'hF;
    bus.peripheralBus_busy = 1;
    smp();
    check("wr_busy_T", 32'(bus.master1_busy), 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(); smp();
      check("wr_we_stall", 32'(bus.peripheralBus_we), 1);
      check("wr_busy_stall", 32'(bus.master1_busy), 1);
    end
    cyc(); bus.peripheralBus_busy = 0; smp();
    check("wr_we_T4", 32'(bus.peripheralBus_we), 1);
    check("wr_data", bus.peripheralBus_dataWrite, 32'hDEADBEEF);
    check("wr_bs", 32'(bus.peripheralBus_byteSelect), 32'hF);
    check("wr_busy_T4", 32'(bus.master1_busy), 0);
    cyc(); idle_masters(); smp();
    check("wr_clr_we", 32'(bus.peripheralBus_we), 0);
    check("wr_clr_data", bus.peripheralBus_dataWrite, 0);

    // contention straight out of reset
    rst = 1; cyc(); rst = 0;
    bus.master0_oe = 1; bus.master0_address = 24'h000100;
    bus.master1_oe = 1; bus.master1_address = 24'h000200;
    smp();
    check("ct_busy0_T", 32'(bus.master0_busy), 1);
    check("ct_busy1_T", 32'(bus.master1_busy), 1);
    cyc(); smp();
    check("ct_first", 32'(bus.peripheralBus_address), 32'h100);
    check("ct_busy0", 32'(bus.master0_busy), 0);
    check("ct_busy1", 32'(bus.master1_busy), 1);
    cyc(); bus.master0_oe = 0; smp();
    check("ct_gap_oe", 32'(bus.peripheralBus_oe), 0);
    check("ct_gap_busy1", 32'(bus.master1_busy), 1);
    cyc(); smp();
    check("ct_second", 32'(bus.peripheralBus_address), 32'h200);
    check("ct_busy1_done", 32'(bus.master1_busy), 0);
    cyc(); idle_masters();
    for (int k = 0; k < 4; k++) begin
      bus.master0_oe = 1; bus.master1_oe = 1;
      cyc(); smp();
      check("rr_addr", 32'(bus.peripheralBus_address),
            (k % 2 == 0) ? 32'h100 : 32'h200);
      cyc(); idle_masters();
    end

    // reset in the middle of a stalled grant
    bus.master1_oe = 1; bus.master1_address = 24'h000300;
    bus.peripheralBus_busy = 1;
    cyc(); smp();
    check("mr_oe", 32'(bus.peripheralBus_oe), 1);
    cyc(); rst = 1; smp();
    check("mr_busy1", 32'(bus.master1_busy), 1);
    check("mr_dr1", bus.master1_dataRead, 32'hFFFF_FFFF);
    cyc(); rst = 0; idle_masters(); smp();
    check("mr_bus_oe", 32'(bus.peripheralBus_oe), 0);
    check("mr_bus_addr", 32'(bus.peripheralBus_address), 0);
    bus.peripheralBus_busy = 0;
    bus.master0_oe = 1; bus.master1_oe = 1;
    cyc(); smp();
    check("mr_tie", 32'(bus.peripheralBus_address), 32'h100);
    cyc(); idle_masters(); cyc();

    // watchdog: peripheral never releases busy
    bus.peripheralBus_busy = 1;
    bus.master0_oe = 1; bus.master0_address = 24'h000400;
    seen_tmo = 0;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      cyc(); smp();
      seen_tmo |= bus.busTimeout;
    end
    check("wd_quiet", 32'(seen_tmo), 0);
    cyc(); smp();
    check("wd_pulse", 32'(bus.busTimeout), 1);
    check("wd_dr0", bus.master0_dataRead, 32'hFFFF_FFFF);
    check("wd_busy0", 32'(bus.master0_busy), 0);
    cyc(); idle_masters(); smp();
    check("wd_idle_oe", 32'(bus.peripheralBus_oe), 0);
    check("wd_tmo_off", 32'(bus.busTimeout), 0);
`else
    for (int i = 0; i < 40; i++) begin
      cyc(); smp();
      seen_tmo |= bus.busTimeout;
    end
    check("wd_none", 32'(seen_tmo), 0);
    check("wd_busy0", 32'(bus.master0_busy), 1);
    check("wd_oe_held", 32'(bus.peripheralBus_oe), 1);
    rst = 1; cyc(); rst = 0; idle_masters();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
